// File: rtl/io_page.sv
// IO page: LED register, UART transmitter and registered read-back.
// Words are selected one-hot by address bits 2..4 inside the page at bit 22.
module io_page #(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD        = 115200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        mem_rstrb,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    output logic [31:0] io_rdata,
    output logic [4:0]  LEDS,
    output logic        TXD
);

    localparam int DIV = CLK_FREQ_HZ / BAUD;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

    tx_state_t     r_state;
    tx_state_t     w_state_nxt;
    logic [CW-1:0] r_baud;
    logic [CW-1:0] w_baud_nxt;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    r_data;
    logic [7:0]    w_data_nxt;
    logic          r_txd;
    logic          w_txd_nxt;
    logic [4:0]    r_leds;
    logic [31:0]   r_rdata;

    logic          w_io;
    logic          w_wr;
    logic          w_rd;
    logic          w_tx_wr;
    logic          w_busy;
    logic          w_baud_end;
    logic [31:0]   w_rdata;
    logic          w_unused;

    assign w_io    = mem_addr[22];
    assign w_wr    = w_io & (|mem_wmask);
    assign w_rd    = w_io & mem_rstrb;
    assign w_tx_wr = w_wr & mem_addr[3];
    assign w_busy  = (r_state != S_IDLE);
    assign w_baud_end = (r_baud == BAUD_LAST);

    // UART_DAT reads as zero, so only LEDS and the busy flag contribute.
    assign w_rdata = (mem_addr[2] ? {27'b0, r_leds} : 32'b0)
                   | (mem_addr[4] ? {22'b0, w_busy, 9'b0} : 32'b0);

    assign w_unused = ^{mem_addr[31:23], mem_addr[21:5], mem_addr[1:0],
                        mem_wdata[31:8]};

    assign io_rdata = r_rdata;
    assign LEDS     = r_leds;
    assign TXD      = r_txd;

    // LED register and registered read data; reads see pre-write values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_leds  <= 5'b0;
            r_rdata <= 32'b0;
        end else begin
            if (w_wr && mem_addr[2]) begin
                r_leds <= mem_wdata[4:0];
            end
            if (w_rd) begin
                r_rdata <= w_rdata;
            end
        end
    end

    // TX state, counters, data latch and the registered serial line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_data  <= 8'd0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_data  <= w_data_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

    // Next-state logic; TXD is computed from the next state so the
    // register shows the new level in the first cycle of each state.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_data_nxt  = r_data;
        w_txd_nxt   = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_tx_wr) begin
                    w_state_nxt = S_START;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_data_nxt  = mem_wdata[7:0];
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_state_nxt = S_DATA;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                end else begin
                    w_baud_nxt = r_baud + CW'(1);
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + CW'(1);
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    w_state_nxt = S_IDLE;
                    w_baud_nxt  = '0;
                end else begin
                    w_baud_nxt = r_baud + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        case (w_state_nxt)
            S_START: w_txd_nxt = 1'b0;
            S_DATA:  w_txd_nxt = w_data_nxt[w_bit_nxt];
            default: w_txd_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_io_page.sv
// Directed bench for io_page with DIV = 10 (1000 Hz clock, 100 baud).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_io_page;

    logic        clk;
    logic        reset;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] io_rdata;
    logic [4:0]  LEDS;
    logic        TXD;

    int n_vec = 0;
    int n_err = 0;

    io_page #(
        .CLK_FREQ_HZ(1000),
        .BAUD(100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mem_addr(mem_addr),
        .mem_rstrb(mem_rstrb),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .io_rdata(io_rdata),
        .LEDS(LEDS),
        .TXD(TXD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level i cycles after the first START cycle.
    function automatic logic exp_txd(input logic [7:0] d, input int i);
        if (i < 10) return 1'b0;
        if (i < 90) return d[(i - 10) / 10];
        return 1'b1;
    endfunction

    task automatic test_reset;
        #1;
        n_vec++;
        if (TXD !== 1'b1) begin
            n_err++;
            $display("FAIL rst_txd got %b want 1", TXD);
        end
        n_vec++;
        if (LEDS !== 5'h00) begin
            n_err++;
            $display("FAIL rst_leds got %h want 00", LEDS);
        end
        n_vec++;
        if (io_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL rst_rdata got %h want 0", io_rdata);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (TXD !== 1'b1) begin
            n_err++;
            $display("FAIL rst_idle_txd got %b want 1", TXD);
        end
    endtask

    task automatic test_leds;
        @(negedge clk);
        mem_addr  = 32'h0040_0004;
        mem_wdata = 32'h0000_001F;
        mem_wmask = 4'hF;
        @(negedge clk);
        mem_wmask = 4'h0;
        mem_rstrb = 1'b1;
        n_vec++;
        if (LEDS !== 5'h1F) begin
            n_err++;
            $display("FAIL leds_wr got %h want 1f", LEDS);
        end
        @(negedge clk);
        mem_rstrb = 1'b0;
        n_vec++;
        if (io_rdata !== 32'h0000_001F) begin
            n_err++;
            $display("FAIL leds_rd got %h want 0000001f", io_rdata);
        end
        mem_wdata = 32'h0000_000A;
        mem_wmask = 4'b0001;
        mem_rstrb = 1'b1;
        @(negedge clk);
        mem_wmask = 4'h0;
        mem_rstrb = 1'b0;
        n_vec++;
        if (io_rdata !== 32'h0000_001F) begin
            n_err++;
            $display("FAIL leds_rw_old got %h want 0000001f", io_rdata);
        end
        n_vec++;
        if (LEDS !== 5'h0A) begin
            n_err++;
            $display("FAIL leds_rw_new got %h want 0a", LEDS);
        end
    endtask

    task automatic test_uart_frame;
        int busy_cnt;
        busy_cnt = 0;
        @(negedge clk);
        mem_addr  = 32'h0040_0018;
        mem_wdata = 32'h0000_0055;
        mem_wmask = 4'hF;
        mem_rstrb = 1'b1;
        @(negedge clk);
        mem_wmask = 4'h0;
        mem_addr  = 32'h0040_0010;
        n_vec++;
        if (io_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL cntl_same_cycle got %h want 0", io_rdata);
        end
        for (int i = 0; i <= 101; i++) begin
            n_vec++;
            if (TXD !== exp_txd(8'h55, i)) begin
                n_err++;
                $display("FAIL frame55_txd cyc %0d got %b want %b",
                         i, TXD, exp_txd(8'h55, i));
            end
            if (io_rdata === 32'h0000_0200) busy_cnt++;
            if (i == 50) begin
                n_vec++;
                if (io_rdata !== 32'h0000_0200) begin
                    n_err++;
                    $display("FAIL cntl_busy got %h want 00000200", io_rdata);
                end
            end
            if (i == 101) begin
                n_vec++;
                if (io_rdata !== 32'h0) begin
                    n_err++;
                    $display("FAIL cntl_after got %h want 0", io_rdata);
                end
            end
            @(negedge clk);
        end
        mem_rstrb = 1'b0;
        n_vec++;
        if (busy_cnt != 100) begin
            n_err++;
            $display("FAIL busy_len got %0d want 100", busy_cnt);
        end
    endtask

    task automatic test_drop_back_to_back;
        logic e;
        @(negedge clk);
        mem_addr  = 32'h0040_0008;
        mem_wdata = 32'h0000_00A5;
        mem_wmask = 4'hF;
        @(negedge clk);
        mem_wmask = 4'h0;
        for (int i = 0; i <= 200; i++) begin
            if (i < 100) e = exp_txd(8'hA5, i);
            else if (i == 100) e = 1'b1;
            else e = exp_txd(8'h3C, i - 101);
            n_vec++;
            if (TXD !== e) begin
                n_err++;
                $display("FAIL b2b_txd cyc %0d got %b want %b", i, TXD, e);
            end
            if (i == 50) begin
                mem_wdata = 32'h0000_00FF;
                mem_wmask = 4'hF;
            end else if (i == 100) begin
                mem_wdata = 32'h0000_003C;
                mem_wmask = 4'hF;
            end else begin
                mem_wmask = 4'h0;
            end
            @(negedge clk);
        end
        mem_wmask = 4'h0;
    endtask

    task automatic test_reset_midframe;
        @(negedge clk);
        mem_addr  = 32'h0040_0008;
        mem_wdata = 32'h0000_00C3;
        mem_wmask = 4'hF;
        @(negedge clk);
        mem_wmask = 4'h0;
        repeat (35) @(negedge clk);
        n_vec++;
        if (TXD !== 1'b0) begin
            n_err++;
            $display("FAIL mid_pre_txd got %b want 0", TXD);
        end
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if (TXD !== 1'b1) begin
            n_err++;
            $display("FAIL mid_abort_txd got %b want 1", TXD);
        end
        n_vec++;
        if (LEDS !== 5'h00) begin
            n_err++;
            $display("FAIL mid_leds got %h want 00", LEDS);
        end
        @(negedge clk);
        reset     = 1'b0;
        mem_addr  = 32'h0040_0018;
        mem_wdata = 32'h0000_0001;
        mem_wmask = 4'hF;
        mem_rstrb = 1'b1;
        @(negedge clk);
        mem_wmask = 4'h0;
        mem_rstrb = 1'b0;
        n_vec++;
        if (io_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL mid_busy got %h want 0", io_rdata);
        end
        for (int i = 0; i < 100; i++) begin
            n_vec++;
            if (TXD !== exp_txd(8'h01, i)) begin
                n_err++;
                $display("FAIL frame01_txd cyc %0d got %b want %b",
                         i, TXD, exp_txd(8'h01, i));
            end
            @(negedge clk);
        end
        n_vec++;
        if (TXD !== 1'b1) begin
            n_err++;
            $display("FAIL frame01_end got %b want 1", TXD);
        end
    endtask

    task automatic test_page_decode;
        int drops;
        drops = 0;
        @(negedge clk);
        mem_addr  = 32'h0040_0004;
        mem_wdata = 32'h0000_0015;
        mem_wmask = 4'hF;
        mem_rstrb = 1'b0;
        @(negedge clk);
        mem_wmask = 4'h0;
        mem_rstrb = 1'b1;
        @(negedge clk);
        mem_rstrb = 1'b0;
        n_vec++;
        if (io_rdata !== 32'h0000_0015) begin
            n_err++;
            $display("FAIL page_setup got %h want 00000015", io_rdata);
        end
        mem_addr  = 32'h0000_001C;
        mem_wdata = 32'h0000_0007;
        mem_wmask = 4'hF;
        mem_rstrb = 1'b1;
        @(negedge clk);
        mem_wmask = 4'h0;
        mem_addr  = 32'h0000_0010;
        @(negedge clk);
        mem_rstrb = 1'b0;
        n_vec++;
        if (LEDS !== 5'h15) begin
            n_err++;
            $display("FAIL page_leds got %h want 15", LEDS);
        end
        n_vec++;
        if (io_rdata !== 32'h0000_0015) begin
            n_err++;
            $display("FAIL page_rdata got %h want 00000015", io_rdata);
        end
        for (int i = 0; i < 20; i++) begin
            if (TXD !== 1'b1) drops++;
            @(negedge clk);
        end
        n_vec++;
        if (drops != 0) begin
            n_err++;
            $display("FAIL page_txd got %0d low cycles want 0", drops);
        end
    endtask

    initial begin
        reset     = 1'b1;
        mem_addr  = 32'h0;
        mem_rstrb = 1'b0;
        mem_wdata = 32'h0;
        mem_wmask = 4'h0;
        test_reset;
        test_leds;
        test_uart_frame;
        test_drop_back_to_back;
        test_reset_midframe;
        test_page_decode;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/io_page.md
IO_PAGE -- requirements
Module: io_page

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 12000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, UART bit rate; DIV = CLK_FREQ_HZ/BAUD (integer floor), DIV >= 2 required.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mem_addr  input  32  processor byte address.
REQ-006 SHALL have port mem_rstrb  input  1  read strobe, one cycle per read.
REQ-007 SHALL have port mem_wdata  input  32  write data.
REQ-008 SHALL have port mem_wmask  input  4  byte write mask; any nonzero value is a write.
REQ-009 SHALL have port io_rdata  output  32  registered read data for IO page.
REQ-010 SHALL have port LEDS  output  5  LED register.
REQ-011 SHALL have port TXD  output  1  UART serial output, idle high.

Function
REQ-012 SHALL decode the IO page as mem_addr[22]=1; all accesses with mem_addr[22]=0 SHALL be ignored and SHALL leave io_rdata unchanged.
REQ-013 SHALL use one-hot word select: mem_addr[2] LEDS, mem_addr[3] UART_DAT, mem_addr[4] UART_CNTL; several set bits select several registers at once.
REQ-014 SHALL load LEDS <= mem_wdata[4:0] on the clock edge of an IO-page write with mem_addr[2]=1.
REQ-015 SHALL load io_rdata on the edge where mem_rstrb=1 and the IO page is selected, so data is valid one cycle after the strobe (same latency as RAM).
REQ-016 Read data SHALL be the OR of the selected sources: LEDS zero-extended (addr[2]), 32'b0 (addr[3]), busy in bit 9 and zeros elsewhere (addr[4]).
REQ-017 UART_DAT write with mem_addr[3]=1 while idle SHALL latch mem_wdata[7:0] and enter START on that edge; busy=1 from the next cycle.
REQ-018 UART_DAT write while busy SHALL be dropped; the frame in flight SHALL be unaffected.
REQ-019 TX state machine SHALL have states IDLE, START, DATA, STOP; busy = (state != IDLE).
REQ-020 IDLE: TXD=1. START: TXD=0 for DIV cycles -> DATA. DATA: TXD=data[bit], LSB first, DIV cycles per bit, 8 bits -> STOP. STOP: TXD=1 for DIV cycles -> IDLE.
REQ-021 Baud counter SHALL count 0..DIV-1 and restart at 0 on every state or bit change; bit counter SHALL count 0..7.
REQ-022 Full frame SHALL last exactly 10*DIV cycles from first START cycle to first IDLE cycle; a new write accepted in the first IDLE cycle SHALL start the next frame back-to-back.
REQ-023 TXD SHALL be driven from a register (glitch-free).
REQ-024 A read of UART_CNTL in the same cycle as an accepted UART_DAT write SHALL return busy=0 (pre-write value).
REQ-025 Simultaneous read and write of LEDS SHALL return the old LEDS value.

Reset
REQ-026 While reset=1: LEDS=0, io_rdata=0, TXD=1, state=IDLE, busy=0, counters=0, data latch=0, regardless of clock.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately (TXD=1 asynchronously); after release the block SHALL accept a new UART_DAT write on the first clock edge.

Verification (CLK_FREQ_HZ=1000, BAUD=100, DIV=10)
REQ-028 Reset then write 0x1F to addr 0x400004, read it back -> LEDS=5'h1F, io_rdata=0x0000001F one cycle after strobe.
REQ-029 Write 0x55 to 0x400008 -> TXD: 10 cycles 0, bits 1,0,1,0,1,0,1,0 each 10 cycles, 10 cycles 1; busy high exactly 100 cycles.
REQ-030 Read 0x400010 during the frame -> io_rdata=0x00000200; after frame -> 0x00000000.
REQ-031 Write 0xA5 then 0xFF to 0x400008 at cycle 50 of the frame -> only 0xA5 transmitted; write 0x3C in first idle cycle -> frame starts with no idle gap.
REQ-032 Assert reset at cycle 35 of a frame -> TXD=1, busy=0 immediately; after release write 0x01 -> clean full frame.
REQ-033 Write 0x07 to 0x000004 (addr[22]=0) and strobe-read it -> LEDS unchanged, io_rdata unchanged.
